// File: rtl/cmp_alu_stage.sv
// Registered compare/select execute stage with a 2-entry skid buffer on a valid/ready handshake.
// Define CMP_ALU_FLAGS_EN to add the out_flags port (Z, LT, LTU) carried alongside each result.
module cmp_alu_stage #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef CMP_ALU_FLAGS_EN
  ,
  output logic [2:0]       out_flags
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t state;

  logic             lt_s;
  logic             lt_u;
  logic             eq;
  logic [WIDTH-1:0] res_d;

  logic [WIDTH-1:0] skid_result;
  logic [TAG_W-1:0] skid_tag;

  logic load_main;
  logic load_skid;
  logic main_from_skid;

  always_comb begin
    lt_s = $signed(in_a) < $signed(in_b);
    lt_u = in_a < in_b;
    eq   = in_a == in_b;
    res_d = '0;
    case (in_op)
      3'b000:  res_d = {{(WIDTH-1){1'b0}}, lt_s};
      3'b001:  res_d = {{(WIDTH-1){1'b0}}, lt_u};
      3'b010:  res_d = {{(WIDTH-1){1'b0}}, eq};
      3'b011:  res_d = {{(WIDTH-1){1'b0}}, ~eq};
      // Ties select A for all four min/max forms.
      3'b100:  res_d = (lt_s || eq) ? in_a : in_b;
      3'b101:  res_d = lt_s ? in_b : in_a;
      3'b110:  res_d = (lt_u || eq) ? in_a : in_b;
      3'b111:  res_d = lt_u ? in_b : in_a;
      default: res_d = '0;
    endcase
  end

  // Storage enables decoded from the registered state; only accepted inputs reach the registers.
  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: load_main = in_valid;
      ONE: begin
        load_main = in_valid && out_ready;
        load_skid = in_valid && !out_ready;
      end
      FULL: begin
        load_main      = out_ready;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (!in_valid && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (in_valid && !out_ready) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end
        end
        FULL: begin
          if (out_ready) begin
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_tag     <= '0;
      skid_result <= '0;
      skid_tag    <= '0;
    end else begin
      if (load_main) begin
        out_result <= main_from_skid ? skid_result : res_d;
        out_tag    <= main_from_skid ? skid_tag : in_tag;
      end
      if (load_skid) begin
        skid_result <= res_d;
        skid_tag    <= in_tag;
      end
    end
  end

`ifdef CMP_ALU_FLAGS_EN
  logic [2:0] flags_d;
  logic [2:0] skid_flags;

  assign flags_d = {lt_u, lt_s, eq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags  <= '0;
      skid_flags <= '0;
    end else begin
      if (load_main) out_flags <= main_from_skid ? skid_flags : flags_d;
      if (load_skid) skid_flags <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_alu_stage.sv
// Scoreboard bench for cmp_alu_stage (WIDTH=8, TAG_W=4); covers out_flags when CMP_ALU_FLAGS_EN is defined.
module tb_cmp_alu_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_tag;
`ifdef CMP_ALU_FLAGS_EN
  logic [2:0] out_flags;
`endif

  cmp_alu_stage #(.WIDTH(8), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef CMP_ALU_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] tag;
    logic [2:0] flags;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb_, ua, ub;
    sa  = a[7] ? int'(a) - 256 : int'(a);
    sb_ = b[7] ? int'(b) - 256 : int'(b);
    ua  = int'(a);
    ub  = int'(b);
    case (op)
      3'd0:    return (sa < sb_) ? 8'd1 : 8'd0;
      3'd1:    return (ua < ub) ? 8'd1 : 8'd0;
      3'd2:    return (a == b) ? 8'd1 : 8'd0;
      3'd3:    return (a != b) ? 8'd1 : 8'd0;
      3'd4:    return (sa <= sb_) ? a : b;
      3'd5:    return (sa >= sb_) ? a : b;
      3'd6:    return (ua <= ub) ? a : b;
      default: return (ua >= ub) ? a : b;
    endcase
  endfunction

  function automatic logic [2:0] fmodel(input logic [7:0] a, input logic [7:0] b);
    int sa, sb_;
    sa  = a[7] ? int'(a) - 256 : int'(a);
    sb_ = b[7] ? int'(b) - 256 : int'(b);
    return {int'(a) < int'(b), sa < sb_, a == b};
  endfunction

  // Check each result in the cycle it is handed downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_tag), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(out_result), 32'(e.result));
        chk("tag", 32'(out_tag), 32'(e.tag));
`ifdef CMP_ALU_FLAGS_EN
        chk("flags", 32'(out_flags), 32'(e.flags));
`endif
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input logic [7:0] exp_res);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    sb.push_back('{result: exp_res, tag: tag, flags: fmodel(a, b)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    in_a = 'x;
    in_b = 'x;
    in_op = 'x;
    in_tag = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(3'd0, 8'h84, 8'h02, 4'd1, 8'h01);
`ifdef CMP_ALU_FLAGS_EN
    chk("flags_84_02", 32'(out_flags), 32'b010);
`endif
    send(3'd1, 8'h84, 8'h02, 4'd2, 8'h00);
    send(3'd0, 8'h82, 8'h84, 4'd3, 8'h01);
    send(3'd1, 8'h82, 8'h84, 4'd4, 8'h01);
    send(3'd4, 8'h80, 8'h7F, 4'd5, 8'h80);
    send(3'd5, 8'h80, 8'h7F, 4'd6, 8'h7F);
    send(3'd6, 8'h80, 8'h7F, 4'd7, 8'h7F);
    send(3'd7, 8'h80, 8'h7F, 4'd8, 8'h80);
    for (int unsigned i = 4; i < 8; i++) send(3'(i), 8'h55, 8'h55, 4'(i + 5), 8'h55);
    send(3'd2, 8'h55, 8'h55, 4'd13, 8'h01);
    send(3'd3, 8'h55, 8'h55, 4'd14, 8'h00);
    send(3'd3, 8'h10, 8'h10, 4'd15, 8'h00);
`ifdef CMP_ALU_FLAGS_EN
    chk("flags_10_10", 32'(out_flags), 32'b001);
`endif
    idle(2);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: two ops fill main and skid.
    out_ready = 1'b0;
    send(3'd5, 8'h01, 8'h02, 4'd1, 8'h02);
    chk("bp_in_ready_one", 32'(in_ready), 32'd1);
    send(3'd6, 8'h03, 8'h04, 4'd2, 8'h03);
    idle(0);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_out_tag_hold", 32'(out_tag), 32'd1);
    idle(3);
    chk("bp_out_tag_stable", 32'(out_tag), 32'd1);
    chk("bp_result_stable", 32'(out_result), 32'h02);
    out_ready = 1'b1;
    idle(1);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_second_tag", 32'(out_tag), 32'd2);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    idle(1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: one accept and one result per cycle.
    for (int unsigned i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = (i % 5 == 0) ? a : 8'($urandom);
      send(op, a, b, 4'(i), model(op, a, b));
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_tag", 32'(out_tag), 32'(i));
    end
    idle(2);
    chk("stream_queue_empty", 32'(sb.size()), 32'd0);

    // Reset while FULL.
    out_ready = 1'b0;
    send(3'd7, 8'hAA, 8'h11, 4'd9, 8'hAA);
    send(3'd4, 8'hF0, 8'h0F, 4'd10, 8'hF0);
    idle(0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_result", 32'(out_result), 32'd0);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(3'd1, 8'h01, 8'hFF, 4'd6, 8'h01);
    chk("post_rst_tag", 32'(out_tag), 32'd6);
    idle(2);
    chk("post_rst_drained", 32'(out_valid), 32'd0);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
